uart_level_bridge: RTL
======================

Name: uart_level_bridge

Overview:
Parametrised multi-channel UART bridge between the 3V3 bank and the VIO bank. It replaces raw pin-to-pin wiring with clocked paths. Each channel carries one line per direction (3V3->VIO and VIO->3V3), and each line is synchronised and deglitched. The block adds a per-channel enable, an activity indicator and break detection on the 3V3->VIO line. It sits directly between the top-level pads of the two banks.

Parameters:
- CHANNELS, 4: number of UART channels, each with one line per direction.
- SYNC_STAGES, 2: flip-flop synchroniser depth per input; legal range 2..4.
- FILTER_LEN, 3: consecutive stable cycles needed before a filtered output changes; 1 means no debounce.
- ACT_STRETCH, 1048576: number of cycles the activity output stays high after an edge.
- BREAK_CYCLES, 65536: consecutive low cycles on a filtered 3V3->VIO line that count as a break.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous, active-high reset.
- en, in, CHANNELS: per-channel enable; 1 = pass data.
- tx_3v3_in, in, CHANNELS: lines from the 3V3 bank, asynchronous.
- tx_vio_out, out, CHANNELS: filtered copy of tx_3v3_in driven into the VIO bank.
- rx_vio_in, in, CHANNELS: lines from the VIO bank, asynchronous.
- rx_3v3_out, out, CHANNELS: filtered copy of rx_vio_in driven into the 3V3 bank.
- act, out, CHANNELS: activity indicator, pulse-stretched.
- brk, out, CHANNELS: break detected on the 3V3->VIO line of that channel.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - synchroniser flops, filtered outputs tx_vio_out and rx_3v3_out = all 1 (UART idle);
  - act = 0, brk = 0;
  - all counters = 0.
- Synchroniser: SYNC_STAGES flops per input line, reset value 1.
- Filter, one per line:
  - The filtered output is a register; the filter counter is ceil(log2(FILTER_LEN+1)) bits wide.
  - If the synchronised input equals the output, the counter clears.
  - Otherwise the counter increments. When it reaches FILTER_LEN-1, the output toggles on that same clock edge and the counter clears.
  - Any input pulse shorter than FILTER_LEN cycles is suppressed entirely.
- Latency: a clean edge at the pin appears on the output SYNC_STAGES+FILTER_LEN clock edges later (5 with defaults). Both directions have identical latency.
- Enable:
  - While en[i]=0, both outputs of channel i are forced to 1, the filter counters are held at 0, and act[i]/brk[i] are cleared.
  - The synchroniser keeps running while disabled.
  - When en[i] rises, the filter restarts from output=1. If the line is low at that point, the output falls after FILTER_LEN cycles, not immediately.
- Activity:
  - An edge on either filtered output of channel i loads the stretch counter with ACT_STRETCH-1.
  - Otherwise a nonzero counter decrements by 1 per cycle.
  - act[i] = (counter != 0) OR (edge this cycle). It is therefore high in the edge cycle and stays high for ACT_STRETCH cycles in total.
  - A new edge while act[i] is already high reloads the counter; there is no accumulation.
- Break:
  - A low-run counter counts consecutive cycles with tx_vio_out[i]=0 and saturates at BREAK_CYCLES.
  - brk[i] sets on the cycle the counter reaches BREAK_CYCLES.
  - brk[i] and the counter clear in the same cycle tx_vio_out[i] returns to 1.
  - The line itself is still passed through low during a break; break detection never blocks data.
- Simultaneous edges on both directions of one channel: a single activity reload, no conflict.
- Channels are fully independent; there is no shared state.
- No combinational path from any input to any output.

Test Plan (CHANNELS=4, SYNC_STAGES=2, FILTER_LEN=3, ACT_STRETCH=8, BREAK_CYCLES=20):
1. Reset, then release rst with all inputs at 1 and en=4'hF -> tx_vio_out=4'hF, rx_3v3_out=4'hF, act=0, brk=0. Assert rst mid-frame -> outputs return to 1 within the same cycle.
2. Drive tx_3v3_in[0] low at cycle 0 -> tx_vio_out[0] falls at edge 5. act[0] is high for 8 cycles, from edge 5 to edge 12. Repeat on rx_vio_in[2] -> rx_3v3_out[2] shows the same latency.
3. Apply low glitches of 1 and 2 cycles on tx_3v3_in[1] -> tx_vio_out[1] stays at 1 and act[1] stays 0. Apply a 3-cycle low pulse -> a 3-cycle low pulse appears on the output.
4. Send a UART byte 0x55 at 16 cycles/bit on every channel in both directions simultaneously -> all outputs reproduce the bit stream exactly, delayed by 5 cycles.
5. Hold tx_3v3_in[3] low for 30 cycles -> brk[3] rises 20 cycles after tx_vio_out[3] falls. brk[3] clears in the cycle tx_vio_out[3] returns to 1.
6. Set en[1]=0 while rx_vio_in[1]=0 -> rx_3v3_out[1]=1 next cycle, act[1]=0. Set en[1]=1 -> rx_3v3_out[1] falls 3 cycles later. Other channels are unaffected throughout.

Source files
------------

// File: rtl/uart_level_bridge.sv
// Multi-channel UART bank bridge with per-line synchroniser and deglitch filter,
// per-channel enable, pulse-stretched activity and break detection.
module uart_level_bridge #(
  parameter int CHANNELS     = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int FILTER_LEN   = 3,
  parameter int ACT_STRETCH  = 1048576,
  parameter int BREAK_CYCLES = 65536
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] en,
  input  logic [CHANNELS-1:0] tx_3v3_in,
  output logic [CHANNELS-1:0] tx_vio_out,
  input  logic [CHANNELS-1:0] rx_vio_in,
  output logic [CHANNELS-1:0] rx_3v3_out,
  output logic [CHANNELS-1:0] act,
  output logic [CHANNELS-1:0] brk
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int AW = $clog2(ACT_STRETCH + 1);
  localparam int BW = $clog2(BREAK_CYCLES + 1);

  localparam logic [FW-1:0] F_LAST = FW'(FILTER_LEN - 1);
  localparam logic [AW-1:0] A_LOAD = AW'(ACT_STRETCH - 1);
  localparam logic [BW-1:0] B_MAX  = BW'(BREAK_CYCLES);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [1:0]    pin;
    logic [1:0]    filt;
    logic [1:0]    hit;
    logic          edge_any;
    logic [AW-1:0] acnt;
    logic [BW-1:0] lcnt;

    // Direction 0 is 3V3->VIO, direction 1 is VIO->3V3
    assign pin = {rx_vio_in[c], tx_3v3_in[c]};

    for (genvar d = 0; d < 2; d++) begin : g_dir
      logic [SYNC_STAGES-1:0] sync;
      logic                   out_q;
      logic                   out_d;
      logic [FW-1:0]          fcnt;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync  <= '1;
          out_q <= 1'b1;
          out_d <= 1'b1;
          fcnt  <= '0;
        end else begin
          sync <= {sync[SYNC_STAGES-2:0], pin[d]};
          if (!en[c]) begin
            out_q <= 1'b1;
            out_d <= 1'b1;
            fcnt  <= '0;
          end else begin
            out_d <= out_q;
            if (sync[SYNC_STAGES-1] == out_q) begin
              fcnt <= '0;
            end else if (fcnt == F_LAST) begin
              out_q <= ~out_q;
              fcnt  <= '0;
            end else begin
              fcnt <= fcnt + 1'b1;
            end
          end
        end
      end

      assign filt[d] = out_q;
      assign hit[d]  = out_q ^ out_d;
    end

    assign edge_any = |hit;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        acnt <= '0;
        lcnt <= '0;
      end else if (!en[c]) begin
        acnt <= '0;
        lcnt <= '0;
      end else begin
        if (edge_any) begin
          acnt <= A_LOAD;
        end else if (acnt != '0) begin
          acnt <= acnt - 1'b1;
        end
        if (filt[0]) begin
          lcnt <= '0;
        end else if (lcnt != B_MAX) begin
          lcnt <= lcnt + 1'b1;
        end
      end
    end

    // Break drops together with the line returning high
    assign tx_vio_out[c] = filt[0];
    assign rx_3v3_out[c] = filt[1];
    assign act[c]        = edge_any | (acnt != '0);
    assign brk[c]        = ~filt[0] & (lcnt == B_MAX);
  end

endmodule
